// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the register file and its writeback scheduler.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping to the bottom.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    // Two passes replace the modulo walk: indices >= ptr first, then the wrapped ones below ptr.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
                o_any      = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (PTR_W'(i) < i_ptr)) begin
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin scheduler for the single register-file write port, with a pending-write
// scoreboard that drives the decode-stage read-after-write stall.
module regfile_wb_scheduler #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned XLEN       = regfile_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0]         req_data,
    output logic                            RegWrite,
    output logic [REG_ADDR_W-1:0]           writeReg,
    output logic [XLEN-1:0]                 writeData,
    input  logic                            issue_valid,
    input  logic [REG_ADDR_W-1:0]           issue_rd,
    input  logic [REG_ADDR_W-1:0]           readReg1,
    input  logic [REG_ADDR_W-1:0]           readReg2,
    output logic                            raw_stall,
    output logic [regfile_pkg::NUM_REGS-1:0] busy_mask
);

    import regfile_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [REG_ADDR_W-1:0] ZERO_RD = REG_ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]          r_rr_ptr;
    logic                      r_reg_write;
    logic [REG_ADDR_W-1:0]     r_write_reg;
    logic [XLEN-1:0]           r_write_data;
    logic [NUM_REGS-1:0]       r_busy;

    logic [NUM_REQ-1:0]        w_grant;
    logic [PTR_W-1:0]          w_grant_idx;
    logic                      w_grant_any;
    logic                      w_xfer;
    logic [REG_ADDR_W-1:0]     w_sel_rd;
    logic [XLEN-1:0]           w_sel_data;
    logic [NUM_REGS-1:0]       w_busy_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    assign req_ready = reset ? '0 : w_grant;
    assign w_xfer    = !reset && w_grant_any;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Clear before set so a same-register issue in the commit cycle keeps the bit.
    always_comb begin
        w_busy_next = r_busy;
        if (r_reg_write) begin
            w_busy_next[r_write_reg] = 1'b0;
        end
        if (issue_valid && (issue_rd != ZERO_RD)) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_xfer) begin
                r_reg_write  <= (w_sel_rd != ZERO_RD);
                r_write_reg  <= w_sel_rd;
                r_write_data <= w_sel_data;
                r_rr_ptr     <= (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
            end else begin
                r_reg_write  <= 1'b0;
            end
        end
    end

    assign RegWrite  = r_reg_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign busy_mask = r_busy;
    assign raw_stall = r_busy[readReg1] | r_busy[readReg2];

endmodule
